// File: rtl/half_duplex_spi_master_mc_if.sv
// Command/status handshake between the register front end and the SPI master.
// master modport: seen by the SPI master (commands in, status/read data out).
// slave modport:  seen by the front end driving commands.
interface half_duplex_spi_master_mc_if #(
  parameter int DATA_WIDTH            = 32,
  parameter int TRANSACTION_LEN_WIDTH = 6,
  parameter int CS_SEL_WIDTH          = 2,
  parameter int CLK_DIV_WIDTH         = 8
) ();
  logic                             cmd_valid;
  logic                             cmd_ready;
  logic [TRANSACTION_LEN_WIDTH-1:0] cmd_length;
  logic [DATA_WIDTH-1:0]            cmd_data;
  logic [DATA_WIDTH-1:0]            cmd_rw_mask;
  logic [CS_SEL_WIDTH-1:0]          cmd_cs_sel;
  logic                             cmd_cpol;
  logic                             cmd_cpha;
  logic [CLK_DIV_WIDTH-1:0]         clk_div;
  logic                             cmd_error;
  logic                             busy;
  logic [DATA_WIDTH-1:0]            rd_data;
  logic                             rd_valid;

  modport master (
    input  cmd_valid, cmd_length, cmd_data, cmd_rw_mask, cmd_cs_sel, cmd_cpol, cmd_cpha, clk_div,
    output cmd_ready, cmd_error, busy, rd_data, rd_valid
  );

  modport slave (
    output cmd_valid, cmd_length, cmd_data, cmd_rw_mask, cmd_cs_sel, cmd_cpol, cmd_cpha, clk_div,
    input  cmd_ready, cmd_error, busy, rd_data, rd_valid
  );
endinterface

// File: rtl/half_duplex_spi_master_mc.sv
// Single-clock, multi-chip-select 3-wire SPI master. SCLK is derived from
// fabric_clk with half-period (clk_div+1); each command carries its own
// CPOL/CPHA, divider, chip select and a per-bit write/read mask.
// Ports: fabric_clk, reset (async, active high), bus (command/status
// handshake, master modport), spi_sdio (bidirectional data), spi_sclk,
// spi_cs_n (active-low chip selects).
module half_duplex_spi_master_mc #(
  parameter int DATA_WIDTH            = 32,
  parameter int TRANSACTION_LEN_WIDTH = 6,
  parameter int NUM_CS                = 4,
  parameter int CS_SEL_WIDTH          = 2,
  parameter int CLK_DIV_WIDTH         = 8
) (
  input  logic                        fabric_clk,
  input  logic                        reset,
  half_duplex_spi_master_mc_if.master bus,
  inout  wire                         spi_sdio,
  output logic                        spi_sclk,
  output logic [NUM_CS-1:0]           spi_cs_n
);
  localparam int EW = TRANSACTION_LEN_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_POL, S_SETUP, S_SHIFT, S_HOLD, S_GAP
  } state_t;

  state_t                           r_state, w_next;
  logic [CLK_DIV_WIDTH-1:0]         r_cnt, r_div;
  logic [TRANSACTION_LEN_WIDTH-1:0] r_len;
  logic [EW-1:0]                    r_edge;
  logic [DATA_WIDTH-1:0]            r_data, r_mask, r_rd_shift, r_rd_data;
  logic [CS_SEL_WIDTH-1:0]          r_cs_sel;
  logic                             r_cpha, r_cur_wr, r_any_rd, r_rd_valid, r_err;
  logic                             r_sdio_oe, r_sdio_o, r_sclk;
  logic [NUM_CS-1:0]                r_cs_n;

  logic                  w_accept, w_illegal, w_tick, w_last_edge, w_leading;
  logic                  w_launch, w_sample, w_ready, w_busy;
  logic [DATA_WIDTH-1:0] w_len_mask;
  logic [NUM_CS-1:0]     w_cs_onehot;

  assign w_accept    = bus.cmd_valid & w_ready;
  assign w_illegal   = (bus.cmd_length == '0) ||
                       (int'(bus.cmd_length) > DATA_WIDTH) ||
                       (int'(bus.cmd_cs_sel) >= NUM_CS);
  // MSB-aligned ones covering the first cmd_length bits
  assign w_len_mask  = ~({DATA_WIDTH{1'b1}} >> bus.cmd_length);
  assign w_tick      = (r_cnt == '0) && (r_state != S_IDLE);
  assign w_last_edge = (r_edge == ({r_len, 1'b0} - EW'(1)));
  assign w_leading   = ~r_edge[0];
  // cpha=0: bit0 goes out on SETUP entry, later bits on trailing edges
  // cpha=1: every bit goes out on its leading edge
  assign w_launch    = (r_state == S_POL && w_tick && !r_cpha) ||
                       (r_state == S_SHIFT && w_tick &&
                        (r_cpha ? w_leading : (!w_leading && !w_last_edge)));
  assign w_sample    = (r_state == S_SHIFT) && w_tick && !r_cur_wr &&
                       (r_cpha ? !w_leading : w_leading);
  assign w_cs_onehot = NUM_CS'(1) << r_cs_sel;

  always_ff @(posedge fabric_clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_busy  = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        w_busy  = 1'b0;
        if (w_accept && !w_illegal) w_next = S_POL;
      end
      S_POL:   if (w_tick) w_next = S_SETUP;
      S_SETUP: if (w_tick) w_next = S_SHIFT;
      S_SHIFT: if (w_tick && w_last_edge) w_next = S_HOLD;
      S_HOLD:  if (w_tick) w_next = S_GAP;
      S_GAP:   if (w_tick) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge fabric_clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_div      <= '0;
      r_len      <= '0;
      r_edge     <= '0;
      r_data     <= '0;
      r_mask     <= '0;
      r_rd_shift <= '0;
      r_rd_data  <= '0;
      r_cs_sel   <= '0;
      r_cpha     <= 1'b0;
      r_cur_wr   <= 1'b0;
      r_any_rd   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
      r_sdio_oe  <= 1'b0;
      r_sdio_o   <= 1'b0;
      r_sclk     <= 1'b0;
      r_cs_n     <= '1;
    end else begin
      r_err      <= 1'b0;
      r_rd_valid <= 1'b0;

      // idle keeps the counter primed so POL starts a full half-period
      if (r_state == S_IDLE) r_cnt <= bus.clk_div;
      else if (w_tick)       r_cnt <= r_div;
      else                   r_cnt <= r_cnt - 1'b1;

      if (w_accept) begin
        r_err      <= w_illegal;
        r_div      <= bus.clk_div;
        r_len      <= bus.cmd_length;
        r_data     <= bus.cmd_data;
        r_mask     <= bus.cmd_rw_mask;
        r_cs_sel   <= bus.cmd_cs_sel;
        r_cpha     <= bus.cmd_cpha;
        r_any_rd   <= |(~bus.cmd_rw_mask & w_len_mask);
        r_rd_shift <= '0;
        r_edge     <= '0;
        if (!w_illegal) r_sclk <= bus.cmd_cpol;
      end

      if (r_state == S_POL && w_tick) r_cs_n <= ~w_cs_onehot;

      if (r_state == S_SHIFT && w_tick) begin
        r_sclk <= ~r_sclk;
        r_edge <= r_edge + 1'b1;
      end

      // data and mask shift together; the MSB is always the next bit to launch
      if (w_launch) begin
        r_sdio_oe <= r_mask[DATA_WIDTH-1];
        r_sdio_o  <= r_data[DATA_WIDTH-1];
        r_cur_wr  <= r_mask[DATA_WIDTH-1];
        r_data    <= r_data << 1;
        r_mask    <= r_mask << 1;
      end

      if (w_sample) r_rd_shift <= {r_rd_shift[DATA_WIDTH-2:0], spi_sdio};

      if (r_state == S_HOLD && w_tick) begin
        r_cs_n     <= '1;
        r_sdio_oe  <= 1'b0;
        r_rd_valid <= r_any_rd;
        if (r_any_rd) r_rd_data <= r_rd_shift;
      end
    end
  end

  assign spi_sdio      = r_sdio_oe ? r_sdio_o : 1'bz;
  assign spi_sclk      = r_sclk;
  assign spi_cs_n      = r_cs_n;
  assign bus.cmd_ready = w_ready;
  assign bus.busy      = w_busy;
  assign bus.cmd_error = r_err;
  assign bus.rd_data   = r_rd_data;
  assign bus.rd_valid  = r_rd_valid;
endmodule
